// File: rtl/terminal_writer_pkg.sv
// Shared types and constants for the terminal writer.
// Build option: TERMINAL_WRITER_TAB_EN enables horizontal tab handling in the top.
package terminal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam int         TAB_STOP  = 8;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/terminal_writer_ring_counter.sv
// Mod-N up-counter with synchronous active-low reset; wrap flags the last value.
module ring_counter #(
    parameter int N = 30,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_low,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Wrap at N explicitly; N need not be a power of two.
    always_comb begin
        wrap    = (count_q == W'(N - 1));
        count_d = count_q;
        if (inc) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/terminal_writer.sv
// Byte stream to character-RAM cell writer with CR/LF/BS, auto-wrap and ring-buffer scroll.
// Build option: define TERMINAL_WRITER_TAB_EN to move the cursor to the next tab stop on 0x09.
module terminal_writer
    import terminal_pkg::*;
#(
    parameter  int         ROWS  = 30,
    parameter  int         COLS  = 100,
    parameter  logic [7:0] BLANK = 8'h20,
    localparam int         ROW_W = $clog2(ROWS),
    localparam int         COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset_low,
    input  logic             write_ready,
    output logic             write_valid,
    output logic [ROW_W-1:0] write_row,
    output logic [COL_W-1:0] write_col,
    output logic [7:0]       write_byte,
    output logic             character_ready,
    input  logic             character_valid,
    input  logic [7:0]       character_byte,
    output logic [ROW_W-1:0] top_row
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LINE_LAST = ROW_W'(ROWS - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   line_count_q, line_count_d;
    logic               wv_q, wv_d;
    logic [ROW_W-1:0]   wr_q, wr_d;
    logic [COL_W-1:0]   wc_q, wc_d;
    logic [7:0]         wb_q, wb_d;

    logic               accept;
    logic               advance;
    logic               row_inc;
    logic               top_inc;
    logic [ROW_W-1:0]   row_q;
    logic               row_wrap;
    logic [ROW_W-1:0]   row_next;
    logic               top_wrap_unused;

`ifdef TERMINAL_WRITER_TAB_EN
    function automatic logic [COL_W-1:0] tab_target(input logic [COL_W-1:0] col);
        int stop;
        stop = (int'(col) / TAB_STOP + 1) * TAB_STOP;
        return (stop > COLS - 1) ? COL_LAST : COL_W'(stop);
    endfunction
`endif

    ring_counter #(.N(ROWS), .W(ROW_W)) u_row (
        .clk       (clk),
        .reset_low (reset_low),
        .inc       (row_inc),
        .count     (row_q),
        .wrap      (row_wrap)
    );

    ring_counter #(.N(ROWS), .W(ROW_W)) u_top (
        .clk       (clk),
        .reset_low (reset_low),
        .inc       (top_inc),
        .count     (top_row),
        .wrap      (top_wrap_unused)
    );

    assign character_ready = (state_q == IDLE) && reset_low;
    assign accept          = character_ready && character_valid;
    assign row_next        = row_wrap ? '0 : row_q + ROW_W'(1);

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_count_d = line_count_q;
        wv_d         = wv_q;
        wr_d         = wr_q;
        wc_d         = wc_q;
        wb_d         = wb_q;
        advance      = 1'b0;
        row_inc      = 1'b0;
        top_inc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(character_byte)) begin
                        wr_d    = row_q;
                        wc_d    = col_q;
                        wb_d    = character_byte;
                        wv_d    = 1'b1;
                        state_d = WRITE;
                    end else if (character_byte == ASCII_CR) begin
                        col_d = '0;
                    end else if (character_byte == ASCII_BS) begin
                        if (col_q != '0) col_d = col_q - COL_W'(1);
                    end else if (character_byte == ASCII_LF) begin
                        advance = 1'b1;
`ifdef TERMINAL_WRITER_TAB_EN
                    end else if (character_byte == ASCII_TAB) begin
                        col_d = tab_target(col_q);
`endif
                    end
                end
            end
            WRITE: begin
                if (write_ready) begin
                    wv_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        advance = 1'b1;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (write_ready) begin
                    if (wc_q == COL_LAST) begin
                        wv_d    = 1'b0;
                        wc_d    = '0;
                        state_d = IDLE;
                    end else begin
                        wc_d = wc_q + COL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line advance: the newly entered row is blanked before new text lands on it.
        if (advance) begin
            col_d   = '0;
            row_inc = 1'b1;
            if (line_count_q == LINE_LAST) top_inc = 1'b1;
            else                           line_count_d = line_count_q + ROW_W'(1);
            wv_d    = 1'b1;
            wr_d    = row_next;
            wc_d    = '0;
            wb_d    = BLANK;
            state_d = CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            state_q      <= IDLE;
            col_q        <= '0;
            line_count_q <= '0;
            wv_q         <= 1'b0;
            wr_q         <= '0;
            wc_q         <= '0;
            wb_q         <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_count_q <= line_count_d;
            wv_q         <= wv_d;
            wr_q         <= wr_d;
            wc_q         <= wc_d;
            wb_q         <= wb_d;
        end
    end

    assign write_valid = wv_q;
    assign write_row   = wr_q;
    assign write_col   = wc_q;
    assign write_byte  = wb_q;

endmodule
